// File: rtl/divider_scheduler_if.sv
// Requester/result/divider signal bundle for divider_scheduler.
// slave: the scheduler; master: requesters plus shared divider (testbench side).
interface divider_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int NBITS = 8,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*NBITS-1:0] numerator_i;
  logic [N_REQ*NBITS-1:0] denominator_i;
  logic [N_REQ-1:0]       ack_o;
  logic                   res_valid_o;
  logic [IDW-1:0]         res_id_o;
  logic [NBITS-1:0]       res_quotient_o;
  logic [NBITS-1:0]       res_remainder_o;
  logic                   res_dbz_o;
  logic                   busy_o;
  logic                   div_valid_o;
  logic [NBITS-1:0]       div_numerator_o;
  logic [NBITS-1:0]       div_denominator_o;
  logic [NBITS-1:0]       div_quotient_i;
  logic [NBITS-1:0]       div_remainder_i;

  modport slave (
    input  req_i, numerator_i, denominator_i, div_quotient_i, div_remainder_i,
    output ack_o, res_valid_o, res_id_o, res_quotient_o, res_remainder_o,
           res_dbz_o, busy_o, div_valid_o, div_numerator_o, div_denominator_o
  );

  modport master (
    output req_i, numerator_i, denominator_i, div_quotient_i, div_remainder_i,
    input  ack_o, res_valid_o, res_id_o, res_quotient_o, res_remainder_o,
           res_dbz_o, busy_o, div_valid_o, div_numerator_o, div_denominator_o
  );
endinterface

// File: rtl/divider_scheduler.sv
// Round-robin scheduler sharing one fixed-latency divider among N_REQ requesters.
// Zero denominators are answered locally (q = all ones, r = numerator) without starting the divider.
module divider_scheduler #(
  parameter int N_REQ       = 4,
  parameter int NBITS       = 8,
  parameter int DIV_LATENCY = NBITS + 2,
  localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input logic           clk_i,
  input logic           arst_i,
  divider_scheduler_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_ZERO    = 3'd4;
  localparam int CW = $clog2(DIV_LATENCY + 1);

  logic [2:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [IDW-1:0]   r_last;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_res_id;
  logic [NBITS-1:0] r_num;
  logic [NBITS-1:0] r_den;
  logic [NBITS-1:0] r_q;
  logic [NBITS-1:0] r_r;
  logic             r_dbz;
  logic             r_res_valid;

  logic             w_gnt_any;
  logic [IDW-1:0]   w_gnt_id;
  logic [NBITS-1:0] w_num [N_REQ];
  logic [NBITS-1:0] w_den [N_REQ];
  logic [N_REQ-1:0] w_ack;

  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_num[k] = bus.numerator_i[k*NBITS +: NBITS];
      w_den[k] = bus.denominator_i[k*NBITS +: NBITS];
    end
  end

  // Scan from farthest to nearest candidate so the one right after r_last wins.
  always_comb begin : arb
    int unsigned    idx;
    logic [IDW-1:0] cand;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      idx = 32'(r_last) + i;
      if (idx >= N_REQ) idx -= N_REQ;
      cand = idx[IDW-1:0];
      if (bus.req_i[cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = cand;
      end
    end
  end

  always_comb begin
    w_ack = '0;
    if (r_state == S_ISSUE || r_state == S_ZERO) w_ack[r_id] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last      <= IDW'(N_REQ - 1);
      r_id        <= '0;
      r_res_id    <= '0;
      r_num       <= '0;
      r_den       <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_dbz       <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_any) begin
            r_last  <= w_gnt_id;
            r_id    <= w_gnt_id;
            r_num   <= w_num[w_gnt_id];
            r_den   <= w_den[w_gnt_id];
            r_state <= (w_den[w_gnt_id] == '0) ? S_ZERO : S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == CW'(DIV_LATENCY - 1)) begin
            r_cnt   <= '0;
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          r_q         <= bus.div_quotient_i;
          r_r         <= bus.div_remainder_i;
          r_dbz       <= 1'b0;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_ZERO: begin
          r_q         <= '1;
          r_r         <= r_num;
          r_dbz       <= 1'b1;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack_o             = w_ack;
  assign bus.res_valid_o       = r_res_valid;
  assign bus.res_id_o          = r_res_id;
  assign bus.res_quotient_o    = r_q;
  assign bus.res_remainder_o   = r_r;
  assign bus.res_dbz_o         = r_dbz;
  assign bus.busy_o            = (r_state != S_IDLE);
  assign bus.div_valid_o       = (r_state == S_ISSUE);
  assign bus.div_numerator_o   = r_num;
  assign bus.div_denominator_o = r_den;
endmodule

// File: tb/tb_divider_scheduler.sv
// Directed checks of divider_scheduler with a latency-10 behavioural divider.
module tb_divider_scheduler;
  localparam int N   = 4;
  localparam int NB  = 8;
  localparam int LAT = 10;

  logic clk = 1'b0;
  logic arst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   dv_cnt = 0;

  divider_scheduler_if #(.N_REQ(N), .NBITS(NB), .IDW(2)) bus ();

  divider_scheduler #(.N_REQ(N), .NBITS(NB), .DIV_LATENCY(LAT)) dut (
    .clk_i(clk), .arst_i(arst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (bus.div_valid_o) dv_cnt++;

  // Divider model: garbage until LAT cycles after the start pulse.
  logic [NB-1:0] m_a, m_b;
  int m_cnt = 0;
  always @(posedge clk) begin
    if (bus.div_valid_o) begin
      m_a <= bus.div_numerator_o;
      m_b <= bus.div_denominator_o;
      m_cnt <= LAT - 1;
      bus.div_quotient_i  <= 8'hA5;
      bus.div_remainder_i <= 8'h5A;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        bus.div_quotient_i  <= (m_b != 0) ? m_a / m_b : '1;
        bus.div_remainder_i <= (m_b != 0) ? m_a % m_b : m_a;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int oh2id(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_op(input int id, input logic [NB-1:0] num, input logic [NB-1:0] den);
    bus.numerator_i[id*NB +: NB]   = num;
    bus.denominator_i[id*NB +: NB] = den;
  endtask

  task automatic run_one(input string tag, input int id, input logic [NB-1:0] num,
                         input logic [NB-1:0] den, input logic [NB-1:0] eq,
                         input logic [NB-1:0] er, input logic edbz);
    int t0, dv0, nack;
    logic got;
    logic [N-1:0] want;
    want = '0;
    want[id] = 1'b1;
    for (int k = 0; k < 40 && bus.busy_o; k++) @(negedge clk);
    @(negedge clk);
    set_op(id, num, den);
    bus.req_i = want;
    t0 = cyc; dv0 = dv_cnt; nack = 0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.ack_o != '0) begin
        nack++;
        if (nack == 1) begin
          chk({tag, " ack"}, 32'(bus.ack_o), 32'(want));
          chk({tag, " ack_lat"}, cyc - t0, 1);
        end
        bus.req_i = '0;
      end
      if (bus.res_valid_o) begin
        got = 1'b1;
        chk({tag, " res_lat"}, cyc - t0, edbz ? 2 : 3 + LAT);
        chk({tag, " id"}, 32'(bus.res_id_o), id);
        chk({tag, " q"}, 32'(bus.res_quotient_o), 32'(eq));
        chk({tag, " r"}, 32'(bus.res_remainder_o), 32'(er));
        chk({tag, " dbz"}, 32'(bus.res_dbz_o), 32'(edbz));
      end
    end
    chk({tag, " res_seen"}, 32'(got), 1);
    chk({tag, " ack_count"}, nack, 1);
    chk({tag, " div_starts"}, dv_cnt - dv0, edbz ? 0 : 1);
  endtask

  initial begin
    int rel, na, nr;
    int acks[8], ackc[8], resc[8];
    logic [NB-1:0] resq[8], resr[8];
    int eq4[4], er4[4], seq[4];

    bus.req_i = '0;
    bus.numerator_i = '0;
    bus.denominator_i = '0;
    set_op(0, 200, 9); set_op(1, 99, 10); set_op(2, 50, 50); set_op(3, 17, 4);
    eq4 = '{22, 9, 1, 4};
    er4 = '{2, 9, 0, 1};
    bus.req_i = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst ack", 32'(bus.ack_o), 0);
    chk("rst res_valid", 32'(bus.res_valid_o), 0);
    chk("rst busy", 32'(bus.busy_o), 0);
    chk("rst div_valid", 32'(bus.div_valid_o), 0);
    chk("rst res_q", 32'(bus.res_quotient_o), 0);

    // All four requesting from reset: grants 0..3, one op every LAT+3 cycles.
    arst = 1'b0;
    rel = cyc; na = 0; nr = 0;
    for (int k = 0; k < 80 && nr < 4; k++) begin
      @(negedge clk);
      if (bus.ack_o != '0 && na < 8) begin
        acks[na] = oh2id(bus.ack_o); ackc[na] = cyc; na++;
        if (na == 4) bus.req_i = '0;
      end
      if (bus.res_valid_o && nr < 8) begin
        resc[nr] = cyc; resq[nr] = bus.res_quotient_o; resr[nr] = bus.res_remainder_o; nr++;
      end
    end
    chk("rr4 acks", na, 4);
    chk("rr4 results", nr, 4);
    for (int k = 0; k < 4 && k < na && k < nr; k++) begin
      chk($sformatf("rr4 id%0d", k), acks[k], k);
      chk($sformatf("rr4 ackcyc%0d", k), ackc[k] - rel, 1 + 13 * k);
      chk($sformatf("rr4 reslat%0d", k), resc[k] - ackc[k], 12);
      chk($sformatf("rr4 q%0d", k), 32'(resq[k]), eq4[k]);
      chk($sformatf("rr4 r%0d", k), 32'(resr[k]), er4[k]);
    end

    run_one("d100_7", 1, 100, 7, 14, 2, 1'b0);
    run_one("dbz55", 3, 55, 0, 255, 55, 1'b1);

    // Fairness: req0 held, req2 joins after the first grant.
    set_op(0, 30, 3); set_op(2, 31, 5);
    @(negedge clk);
    bus.req_i = 4'b0001;
    na = 0; nr = 0;
    for (int k = 0; k < 100 && nr < 4; k++) begin
      @(negedge clk);
      if (bus.ack_o != '0 && na < 8) begin
        acks[na] = oh2id(bus.ack_o); na++;
        if (na == 1) bus.req_i = 4'b0101;
        if (na == 4) bus.req_i = '0;
      end
      if (bus.res_valid_o) nr++;
    end
    seq = '{0, 2, 0, 2};
    chk("fair acks", na, 4);
    for (int k = 0; k < 4 && k < na; k++) chk($sformatf("fair id%0d", k), acks[k], seq[k]);

    run_one("d255_1", 1, 255, 1, 255, 0, 1'b0);
    run_one("d5_9", 2, 5, 9, 0, 5, 1'b0);
    run_one("d0_3", 0, 0, 3, 0, 0, 1'b0);

    // Reset while the divider is running.
    @(negedge clk);
    set_op(1, 100, 7);
    bus.req_i = 4'b0010;
    for (int k = 0; k < 10 && bus.ack_o == '0; k++) @(negedge clk);
    bus.req_i = '0;
    repeat (3) @(negedge clk);
    #2 arst = 1'b1;
    #1;
    chk("mid_rst ack", 32'(bus.ack_o), 0);
    chk("mid_rst busy", 32'(bus.busy_o), 0);
    chk("mid_rst div_valid", 32'(bus.div_valid_o), 0);
    chk("mid_rst div_num", 32'(bus.div_numerator_o), 0);
    chk("mid_rst res_q", 32'(bus.res_quotient_o), 0);
    set_op(0, 200, 9); set_op(1, 99, 10); set_op(2, 50, 50); set_op(3, 17, 4);
    bus.req_i = 4'b1111;
    @(negedge clk);
    arst = 1'b0;
    rel = cyc; na = 0; nr = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.ack_o != '0) begin
        if (na == 0) begin
          chk("post_rst ack", 32'(bus.ack_o), 1);
          chk("post_rst ack_lat", cyc - rel, 1);
        end
        na++;
        bus.req_i = '0;
      end
      if (bus.res_valid_o) begin
        nr++;
        chk("post_rst res_id", 32'(bus.res_id_o), 0);
        chk("post_rst res_q", 32'(bus.res_quotient_o), 22);
        chk("post_rst res_lat", cyc - rel, 13);
      end
    end
    chk("post_rst results", nr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
